// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: operation codes and FSM states.
package shift_reg_pkg;

   typedef enum logic [2:0] {
      MODE_NOP  = 3'b000,
      MODE_SLL  = 3'b001,
      MODE_SRL  = 3'b010,
      MODE_LOAD = 3'b011,
      MODE_ROL  = 3'b100,
      MODE_ROR  = 3'b101,
      MODE_ASR  = 3'b110,
      MODE_CLR  = 3'b111
   } mode_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step datapath: one bit of shift or rotate plus the bit that leaves.
module shift_step
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] data,
   input  mode_e            mode,
   input  logic             serial_in,
   output logic [WIDTH-1:0] next_data,
   output logic             out_bit
);

   // Non-shifting codes pass the data through; the FSM never steps with them.
   always_comb begin
      next_data = data;
      out_bit   = 1'b0;
      case (mode)
         MODE_SLL: begin
            next_data = {data[WIDTH-2:0], serial_in};
            out_bit   = data[WIDTH-1];
         end
         MODE_SRL: begin
            next_data = {serial_in, data[WIDTH-1:1]};
            out_bit   = data[0];
         end
         MODE_ROL: begin
            next_data = {data[WIDTH-2:0], data[WIDTH-1]};
            out_bit   = data[WIDTH-1];
         end
         MODE_ROR: begin
            next_data = {data[0], data[WIDTH-1:1]};
            out_bit   = data[0];
         end
         MODE_ASR: begin
            next_data = {data[WIDTH-1], data[WIDTH-1:1]};
            out_bit   = data[0];
         end
         default: begin
            next_data = data;
            out_bit   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: single-cycle load/clear/nop, multi-cycle shift and rotate
// sequenced one bit per enabled edge by a two-state FSM.
module shift_reg_univ
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_mode,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] data_in,
   input  logic             serial_in,
   output logic [WIDTH-1:0] data_out,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             sout_q, sout_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] stepData;
   logic             stepBit;
   logic [CNT_W-1:0] cntSat;
   mode_e            cmdMode;

   assign cmdMode = mode_e'(cmd_mode);
   assign cntSat  = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .data      (data_q),
      .mode      (mode_q),
      .serial_in (serial_in),
      .next_data (stepData),
      .out_bit   (stepBit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_NOP;
         cnt_q   <= '0;
         data_q  <= '0;
         sout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         sout_q  <= sout_d;
         done_q  <= done_d;
      end
   end

   // With enable low every register keeps its value, including a pending done pulse.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      sout_d  = sout_q;
      done_d  = done_q;
      if (enable) begin
         done_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid) begin
                  case (cmdMode)
                     MODE_LOAD: begin
                        data_d = data_in;
                        done_d = 1'b1;
                     end
                     MODE_CLR: begin
                        data_d = '0;
                        done_d = 1'b1;
                     end
                     MODE_NOP: done_d = 1'b1;
                     default: begin
                        if (cntSat == '0) begin
                           done_d = 1'b1;
                        end else begin
                           mode_d  = cmdMode;
                           cnt_d   = cntSat;
                           state_d = ST_SHIFT;
                        end
                     end
                  endcase
               end
            end
            ST_SHIFT: begin
               data_d = stepData;
               sout_d = stepBit;
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign data_out   = data_q;
   assign serial_out = sout_q;
   assign done       = done_q;
   assign busy       = (state_q == ST_SHIFT);
   assign cmd_ready  = (state_q == ST_IDLE);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed self-checking bench for shift_reg_univ at WIDTH=8.
module tb_shift_reg_univ;
   import shift_reg_pkg::*;

   localparam int WIDTH = 8;
   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic             clk;
   logic             reset;
   logic             enable;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_mode;
   logic [CNT_W-1:0] cmd_count;
   logic [WIDTH-1:0] data_in;
   logic             serial_in;
   logic [WIDTH-1:0] data_out;
   logic             serial_out;
   logic             busy;
   logic             done;

   int cmpCount = 0;
   int errCount = 0;
   int busyCycles;

   shift_reg_univ #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_mode   (cmd_mode),
      .cmd_count  (cmd_count),
      .data_in    (data_in),
      .serial_in  (serial_in),
      .data_out   (data_out),
      .serial_out (serial_out),
      .busy       (busy),
      .done       (done)
   );

   // Free-running clock, rising edge active; the bench acts on falling edges.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      cmpCount++;
      assert (observed === expected)
      else begin
         errCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents one command for exactly one rising edge, returns at the following falling edge.
   task automatic applyStimulus(input mode_e mode, input int count,
                                input logic [WIDTH-1:0] din, input logic sin);
      cmd_mode  = mode;
      cmd_count = CNT_W'(count);
      data_in   = din;
      serial_in = sin;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_done"}, 64'(done), 64'd1);
   endtask

   task automatic countBusy(input int budget);
      busyCycles = 0;
      while (busy === 1'b1 && busyCycles < budget) begin
         busyCycles++;
         @(negedge clk);
      end
   endtask

   initial begin
      reset     = 1'b0;
      enable    = 1'b0;
      cmd_valid = 1'b0;
      cmd_mode  = 3'b000;
      cmd_count = '0;
      data_in   = '0;
      serial_in = 1'b0;

      #1;
      checkOutput("rst_data", 64'(data_out), 64'h0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_ready", 64'(cmd_ready), 64'd1);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_sout", 64'(serial_out), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset  = 1'b1;
      enable = 1'b1;
      @(negedge clk);

      // LOAD 0xA5 then SLL by 3 with ones shifted in
      applyStimulus(MODE_LOAD, 0, 8'hA5, 1'b0);
      checkOutput("load_a5", 64'(data_out), 64'hA5);
      checkOutput("load_done", 64'(done), 64'd1);
      applyStimulus(MODE_SLL, 3, 8'h00, 1'b1);
      checkOutput("sll_accept_data", 64'(data_out), 64'hA5);
      checkOutput("sll_accept_busy", 64'(busy), 64'd1);
      checkOutput("sll_accept_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      checkOutput("sll_s1_data", 64'(data_out), 64'h4B);
      checkOutput("sll_s1_sout", 64'(serial_out), 64'd1);
      checkOutput("sll_s1_busy", 64'(busy), 64'd1);
      @(negedge clk);
      checkOutput("sll_s2_data", 64'(data_out), 64'h97);
      checkOutput("sll_s2_sout", 64'(serial_out), 64'd0);
      checkOutput("sll_s2_busy", 64'(busy), 64'd1);
      checkOutput("sll_s2_done", 64'(done), 64'd0);
      @(negedge clk);
      checkOutput("sll_s3_data", 64'(data_out), 64'h2F);
      checkOutput("sll_s3_sout", 64'(serial_out), 64'd1);
      checkOutput("sll_s3_busy", 64'(busy), 64'd0);
      checkOutput("sll_s3_done", 64'(done), 64'd1);
      checkOutput("sll_s3_ready", 64'(cmd_ready), 64'd1);
      @(negedge clk);
      checkOutput("sll_done_pulse", 64'(done), 64'd0);
      checkOutput("sll_hold_data", 64'(data_out), 64'h2F);

      // ROR by a full width returns the original value
      applyStimulus(MODE_LOAD, 0, 8'h81, 1'b0);
      applyStimulus(MODE_ROR, 8, 8'h00, 1'b0);
      countBusy(20);
      checkOutput("ror_busy_cycles", 64'(busyCycles), 64'd8);
      checkOutput("ror_data", 64'(data_out), 64'h81);
      checkOutput("ror_sout", 64'(serial_out), 64'd1);
      checkOutput("ror_done", 64'(done), 64'd1);

      // Arithmetic then logical right shifts
      applyStimulus(MODE_LOAD, 0, 8'h80, 1'b0);
      applyStimulus(MODE_ASR, 3, 8'h00, 1'b1);
      waitDone("asr", 10);
      checkOutput("asr_data", 64'(data_out), 64'hF0);
      applyStimulus(MODE_SRL, 4, 8'h00, 1'b0);
      waitDone("srl", 10);
      checkOutput("srl_data", 64'(data_out), 64'h0F);
      checkOutput("srl_sout", 64'(serial_out), 64'd0);

      // SLL by 4 with two stalled edges after the first step
      applyStimulus(MODE_LOAD, 0, 8'h01, 1'b0);
      applyStimulus(MODE_SLL, 4, 8'h00, 1'b0);
      @(negedge clk);
      checkOutput("stall_s1_data", 64'(data_out), 64'h02);
      enable = 1'b0;
      @(negedge clk);
      checkOutput("stall_a_data", 64'(data_out), 64'h02);
      checkOutput("stall_a_busy", 64'(busy), 64'd1);
      @(negedge clk);
      checkOutput("stall_b_data", 64'(data_out), 64'h02);
      enable = 1'b1;
      @(negedge clk);
      checkOutput("stall_s2_data", 64'(data_out), 64'h04);
      @(negedge clk);
      checkOutput("stall_s3_data", 64'(data_out), 64'h08);
      checkOutput("stall_s3_done", 64'(done), 64'd0);
      @(negedge clk);
      checkOutput("stall_s4_data", 64'(data_out), 64'h10);
      checkOutput("stall_s4_done", 64'(done), 64'd1);

      // cmd_valid held while busy is ignored, then accepted back-to-back with done
      applyStimulus(MODE_LOAD, 0, 8'h3C, 1'b0);
      applyStimulus(MODE_SRL, 2, 8'h00, 1'b0);
      cmd_mode  = MODE_LOAD;
      data_in   = 8'hFF;
      cmd_valid = 1'b1;
      @(negedge clk);
      checkOutput("ign_s1_data", 64'(data_out), 64'h1E);
      @(negedge clk);
      checkOutput("ign_s2_data", 64'(data_out), 64'h0F);
      checkOutput("ign_s2_done", 64'(done), 64'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      checkOutput("b2b_data", 64'(data_out), 64'hFF);
      checkOutput("b2b_done", 64'(done), 64'd1);

      // Zero count acts as NOP; NOP ignores data_in
      applyStimulus(MODE_SLL, 0, 8'h00, 1'b0);
      checkOutput("cnt0_data", 64'(data_out), 64'hFF);
      checkOutput("cnt0_done", 64'(done), 64'd1);
      checkOutput("cnt0_busy", 64'(busy), 64'd0);
      applyStimulus(MODE_NOP, 0, 8'h12, 1'b0);
      checkOutput("nop_data", 64'(data_out), 64'hFF);
      checkOutput("nop_done", 64'(done), 64'd1);

      // Count above WIDTH saturates: ROL 12 of 0x01 ends at 0x01, not 0x10
      applyStimulus(MODE_LOAD, 0, 8'h01, 1'b0);
      applyStimulus(MODE_ROL, 12, 8'h00, 1'b0);
      countBusy(20);
      checkOutput("sat_busy_cycles", 64'(busyCycles), 64'd8);
      checkOutput("sat_data", 64'(data_out), 64'h01);

      applyStimulus(MODE_CLR, 0, 8'h00, 1'b0);
      checkOutput("clr_data", 64'(data_out), 64'h00);
      checkOutput("clr_done", 64'(done), 64'd1);

      // Asynchronous reset during the second step of SRL by 5
      applyStimulus(MODE_LOAD, 0, 8'hA5, 1'b0);
      applyStimulus(MODE_SRL, 5, 8'h00, 1'b1);
      @(negedge clk);
      checkOutput("rst_mid_s1", 64'(data_out), 64'hD2);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rst_mid_data", 64'(data_out), 64'h00);
      checkOutput("rst_mid_busy", 64'(busy), 64'd0);
      checkOutput("rst_mid_ready", 64'(cmd_ready), 64'd1);
      checkOutput("rst_mid_sout", 64'(serial_out), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("rst_no_done", 64'(done), 64'd0);
      end
      checkOutput("rst_after_data", 64'(data_out), 64'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
